mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter DATA_W, default 32: width of the ALU_out input.
REQ-002 Parameter TIMEOUT, default 16, legal range >= 2: maximum number of cycles spent in MEM before the access is abandoned.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 Port clk, input, 1: the block's single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port Instr, input, 32: instruction word from instruction memory; sampled in FETCH.
REQ-007 Port ALU_out, input, DATA_W: ALU result; used for the beq zero test in EXEC.
REQ-008 Port mem_ready, input, 1: data memory completes the current access this cycle.
REQ-009 Port state, output, 3: current state; FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-010 Ports PCWrite and IRWrite, outputs, 1 each: PC update strobe and instruction-register load strobe.
REQ-011 Port ctrl, output, 2: next-PC select; 0=PC+4, 1=branch target, 2=jump target, 3=register (jr).
REQ-012 Port WE, output, 1: GRF write strobe.
REQ-013 Port GRF_op1, output, 2: destination select; 0=rd, 1=rt, 2=$ra.
REQ-014 Port GRF_op2, output, 2: write-data select; 0=ALU, 1=memory, 2=lui immediate, 3=PC+4.
REQ-015 Port op, output, 2: ALU operation; 0=add, 1=sub, 2=or, 3=compare (beq).
REQ-016 Port ALU_op, output, 2: ALU B-operand source; 0=register, 1=zero-extended immediate, 2=sign-extended immediate.
REQ-017 Ports mem_req and MemWrite, outputs, 1 each: data-memory request and write enable.
REQ-018 Ports illegal and timeout, outputs, 1 each: single-cycle error pulses.
REQ-019 Port retired_cnt, output, CNT_W: count of completed instructions.

Function
REQ-020 The controller SHALL hold an internal 32-bit ir register, loaded from Instr in FETCH; all decoding SHALL use ir, not Instr.
REQ-021 Decoded instruction set: add, sub, ori, lw, sw, beq, lui, jal, jr, j (opcode 000010), and nop (ir==0). Any other encoding SHALL be illegal.
REQ-022 op, ALU_op, GRF_op1 and GRF_op2 SHALL be combinational from ir, encoded as in REQ-013 to REQ-016; all are 0 for j, jr and nop.
REQ-023 FETCH: IRWrite=1, PCWrite=1, ctrl=0; next state DECODE unconditionally.
REQ-024 DECODE: illegal ir pulses illegal=1 and goes to FETCH; nop goes to FETCH; all other instructions go to EXEC.
REQ-025 EXEC, beq: PCWrite=1 with ctrl=1 only if ALU_out==0, otherwise PCWrite=0; next state FETCH.
REQ-026 EXEC, j and jr: PCWrite=1 with ctrl=2 (j) or ctrl=3 (jr); next state FETCH.
REQ-027 EXEC, jal: PCWrite=1, ctrl=2; next state WB.
REQ-028 EXEC, lw or sw: next state MEM. EXEC, add/sub/ori/lui: next state WB.
REQ-029 MEM: mem_req=1, with MemWrite=1 for sw only. On mem_ready=1, lw goes to WB and sw goes to FETCH; the wait counter clears on leaving MEM.
REQ-030 MEM with mem_ready=0: wait counter increments. When the counter equals TIMEOUT-1 and mem_ready=0, timeout pulses 1, the state goes to FETCH, and there is no WB. mem_ready=1 in that same cycle SHALL take precedence over the timeout.
REQ-031 WB: WE=1 for exactly one cycle; next state FETCH.
REQ-032 Outside the states above, PCWrite, IRWrite, ctrl, WE, mem_req and MemWrite SHALL be 0.
REQ-033 retired_cnt SHALL increment by 1, wrapping modulo 2^CNT_W, on each legal instruction's final cycle:
  - nop in DECODE
  - beq, j, jr in EXEC
  - sw in MEM when mem_ready=1
  - WB
  Illegal and timed-out instructions SHALL NOT count.
REQ-034 Latency: add = 4 cycles; lw = 5 cycles + memory wait; beq/j/jr = 3 cycles; nop = 2 cycles.

Reset
REQ-035 While reset_n=0, regardless of clk:
  - state=FETCH, ir=0, wait counter=0, retired_cnt=0
  - all strobes, illegal and timeout = 0
REQ-036 Reset asserted mid-instruction SHALL abort the instruction with no WE, MemWrite or PCWrite afterwards; after release, the first edge performs FETCH.

Verification
REQ-037 Instr=0x00221820 (add $3,$1,$2) after reset -> FETCH, DECODE, EXEC, WB; WE=1 with GRF_op1=0, GRF_op2=0 in WB; retired_cnt=1.
REQ-038 Instr=0x8C050004 (lw), mem_ready low for 3 cycles -> mem_req=1 for 4 cycles, then WB with GRF_op1=1, GRF_op2=1, ALU_op=2.
REQ-039 Instr=0x10000001 (beq) with ALU_out=0, then with ALU_out=5 -> PCWrite=1, ctrl=1 in EXEC in the first case; PCWrite=0 in EXEC in the second.
REQ-040 Instr=0x0C000010 (jal) -> EXEC: PCWrite=1, ctrl=2; WB: WE=1, GRF_op1=2, GRF_op2=3.
REQ-041 Instr=0xFC000000 -> illegal=1 in DECODE, back to FETCH, retired_cnt unchanged. Instr=0xAC000000 (sw), mem_ready held 0 -> timeout=1 after 16 MEM cycles, no write completes.
REQ-042 retired_cnt preloaded to 0xFFFF via 65535 nops, then one more nop -> retired_cnt wraps to 0.

Source files
------------

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction, ALU, memory and control signals of the multi-cycle controller
interface mc_controller_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [31:0]       Instr;
   logic [DATA_W-1:0] ALU_out;
   logic              mem_ready;
   logic [2:0]        state;
   logic              PCWrite;
   logic              IRWrite;
   logic [1:0]        ctrl;
   logic              WE;
   logic [1:0]        GRF_op1;
   logic [1:0]        GRF_op2;
   logic [1:0]        op;
   logic [1:0]        ALU_op;
   logic              mem_req;
   logic              MemWrite;
   logic              illegal;
   logic              timeout;
   logic [CNT_W-1:0]  retired_cnt;
   modport master (
      input  Instr, ALU_out, mem_ready,
      output state, PCWrite, IRWrite, ctrl, WE, GRF_op1, GRF_op2, op, ALU_op,
      output mem_req, MemWrite, illegal, timeout, retired_cnt
   );
   modport slave (
      output Instr, ALU_out, mem_ready,
      input  state, PCWrite, IRWrite, ctrl, WE, GRF_op1, GRF_op2, op, ALU_op,
      input  mem_req, MemWrite, illegal, timeout, retired_cnt
   );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS-subset control FSM with memory timeout and retired-instruction counter
module mc_controller #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic             clk,
   input logic             reset_n,
   mc_controller_if.master bus
);
   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam int WAIT_W = $clog2(TIMEOUT);

   logic [2:0]        state_q, state_d;
   logic [31:0]       ir_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [5:0]        opc, fn;
   logic [DATA_W-1:0] alu;
   logic              is_nop, is_add, is_sub, is_jr, is_ori, is_lw, is_sw;
   logic              is_beq, is_lui, is_jal, is_j, legal, zero, last_wait;
   logic              retire, pcw, irw, we, mreq, mw, ill, tmo;
   logic [1:0]        ctrl;

   assign opc       = ir_q[31:26];
   assign fn        = ir_q[5:0];
   assign alu       = bus.ALU_out;
   assign zero      = alu == '0;
   assign last_wait = wait_q == WAIT_W'(TIMEOUT - 1);
   assign is_nop    = ir_q == '0;
   assign is_add    = opc == 6'h00 && fn == 6'h20;
   assign is_sub    = opc == 6'h00 && fn == 6'h22;
   assign is_jr     = opc == 6'h00 && fn == 6'h08;
   assign is_ori    = opc == 6'h0D;
   assign is_lw     = opc == 6'h23;
   assign is_sw     = opc == 6'h2B;
   assign is_beq    = opc == 6'h04;
   assign is_lui    = opc == 6'h0F;
   assign is_jal    = opc == 6'h03;
   assign is_j      = opc == 6'h02;
   assign legal     = is_nop | is_add | is_sub | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal | is_j;

   assign bus.op      = is_sub ? 2'd1 : is_ori ? 2'd2 : is_beq ? 2'd3 : 2'd0;
   assign bus.ALU_op  = (is_ori | is_lui) ? 2'd1 : (is_lw | is_sw) ? 2'd2 : 2'd0;
   assign bus.GRF_op1 = is_jal ? 2'd2 : (is_ori | is_lw | is_lui) ? 2'd1 : 2'd0;
   assign bus.GRF_op2 = is_jal ? 2'd3 : is_lui ? 2'd2 : is_lw ? 2'd1 : 2'd0;

   // next state, strobes and retire decision; everything is held quiet while reset is asserted
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      retire  = 1'b0;
      pcw     = 1'b0;
      irw     = 1'b0;
      ctrl    = 2'd0;
      we      = 1'b0;
      mreq    = 1'b0;
      mw      = 1'b0;
      ill     = 1'b0;
      tmo     = 1'b0;
      if (reset_n) begin
         case (state_q)
            FETCH: begin
               irw     = 1'b1;
               pcw     = 1'b1;
               state_d = DECODE;
            end
            DECODE: begin
               ill     = !legal;
               retire  = is_nop;
               state_d = (!legal || is_nop) ? FETCH : EXEC;
            end
            EXEC: begin
               pcw     = (is_beq && zero) || is_j || is_jr || is_jal;
               ctrl    = is_beq ? {1'b0, zero} : is_jr ? 2'd3 : (is_j || is_jal) ? 2'd2 : 2'd0;
               retire  = is_beq || is_j || is_jr;
               state_d = (is_lw || is_sw) ? MEM : (is_beq || is_j || is_jr) ? FETCH : WB;
            end
            MEM: begin
               mreq    = 1'b1;
               mw      = is_sw;
               tmo     = !bus.mem_ready && last_wait;
               retire  = bus.mem_ready && is_sw;
               wait_d  = (bus.mem_ready || tmo) ? '0 : wait_q + WAIT_W'(1);
               state_d = bus.mem_ready ? (is_lw ? WB : FETCH) : tmo ? FETCH : MEM;
            end
            WB: begin
               we      = 1'b1;
               retire  = 1'b1;
               state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // state, instruction register, memory wait counter and retire counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         ir_q    <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (irw) ir_q <= bus.Instr;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.state       = state_q;
   assign bus.PCWrite     = pcw;
   assign bus.IRWrite     = irw;
   assign bus.ctrl        = ctrl;
   assign bus.WE          = we;
   assign bus.mem_req     = mreq;
   assign bus.MemWrite    = mw;
   assign bus.illegal     = ill;
   assign bus.timeout     = tmo;
   assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized and directed check of mc_controller against a per-instruction trace model
module tb_mc_controller;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int CW = 8;

   typedef enum {K_NOP, K_ADD, K_SUB, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_J, K_ILL} kind_e;
   typedef struct packed {
      logic [2:0]    st;
      logic          pcw;
      logic          irw;
      logic [1:0]    ctrl;
      logic          we;
      logic [1:0]    g1;
      logic [1:0]    g2;
      logic [1:0]    op;
      logic [1:0]    aop;
      logic          mreq;
      logic          mw;
      logic          ill;
      logic          to;
      logic [CW-1:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   obs_t exp_q[$];
   string tag_q[$];
   logic [31:0] m_ir = '0;
   logic [CW-1:0] m_cnt = '0;
   bit skip_edge = 1'b0;

   always #5 clk = ~clk;

   mc_controller_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
   mc_controller #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   function automatic obs_t observe();
      return {bus.state, bus.PCWrite, bus.IRWrite, bus.ctrl, bus.WE, bus.GRF_op1, bus.GRF_op2,
              bus.op, bus.ALU_op, bus.mem_req, bus.MemWrite, bus.illegal, bus.timeout, bus.retired_cnt};
   endfunction

   function automatic kind_e kind_of(input logic [31:0] w);
      logic [5:0] o = w[31:26];
      logic [5:0] f = w[5:0];
      if (w == 32'h0) return K_NOP;
      if (o == 6'h00) return f == 6'h20 ? K_ADD : f == 6'h22 ? K_SUB : f == 6'h08 ? K_JR : K_ILL;
      case (o)
         6'h0D: return K_ORI;
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h04: return K_BEQ;
         6'h0F: return K_LUI;
         6'h03: return K_JAL;
         6'h02: return K_J;
         default: return K_ILL;
      endcase
   endfunction

   // {op, ALU_op, GRF_op1, GRF_op2} each instruction asks for
   function automatic logic [7:0] attrs(input kind_e k);
      case (k)
         K_SUB: return {2'd1, 2'd0, 2'd0, 2'd0};
         K_ORI: return {2'd2, 2'd1, 2'd1, 2'd0};
         K_LW:  return {2'd0, 2'd2, 2'd1, 2'd1};
         K_SW:  return {2'd0, 2'd2, 2'd0, 2'd0};
         K_BEQ: return {2'd3, 2'd0, 2'd0, 2'd0};
         K_LUI: return {2'd0, 2'd1, 2'd1, 2'd2};
         K_JAL: return {2'd0, 2'd0, 2'd2, 2'd3};
         default: return 8'h00;
      endcase
   endfunction

   function automatic obs_t base(input logic [2:0] st);
      obs_t o = '0;
      o.st = st;
      {o.op, o.aop, o.g1, o.g2} = attrs(kind_of(m_ir));
      o.cnt = m_cnt;
      return o;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      case ($urandom_range(0, 11))
         0:  return 32'h0;
         1:  return {6'h00, r[25:6], 6'h20};
         2:  return {6'h00, r[25:6], 6'h22};
         3:  return {6'h00, r[25:6], 6'h08};
         4:  return {6'h0D, r[25:0]};
         5:  return {6'h23, r[25:0]};
         6:  return {6'h2B, r[25:0]};
         7:  return {6'h04, r[25:0]};
         8:  return {6'h0F, r[25:0]};
         9:  return {6'h03, r[25:0]};
         10: return {6'h02, r[25:0]};
         default: return r;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, got, req);
      end
   endtask

   task automatic step(input obs_t e, input logic mr, input logic [DW-1:0] alu, input logic [31:0] ins, input string tag);
      if (skip_edge) skip_edge = 1'b0;
      else begin
         @(posedge clk);
         #1;
      end
      bus.mem_ready = mr;
      bus.ALU_out = alu;
      bus.Instr = ins;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Plays one instruction cycle by cycle; nwait = cycles mem_ready stays low, limit>0 stops early
   task automatic run_instr(input logic [31:0] w, input logic [DW-1:0] alu, input int nwait, input int limit, output int ncyc);
      kind_e k = kind_of(w);
      string t = k.name();
      obs_t e;
      bit rdy;
      ncyc = 0;
      e = base(3'd0);
      e.pcw = 1'b1;
      e.irw = 1'b1;
      step(e, 1'($urandom), alu, w, t);
      m_ir = w;
      if (++ncyc == limit) return;
      e = base(3'd1);
      e.ill = k == K_ILL;
      step(e, 1'($urandom), alu, $urandom, t);
      if (k == K_NOP) m_cnt++;
      if (++ncyc == limit || k == K_ILL || k == K_NOP) return;
      e = base(3'd2);
      if (k == K_BEQ) begin
         e.pcw = alu == '0;
         e.ctrl = alu == '0 ? 2'd1 : 2'd0;
      end
      if (k == K_J || k == K_JAL) {e.pcw, e.ctrl} = {1'b1, 2'd2};
      if (k == K_JR) {e.pcw, e.ctrl} = {1'b1, 2'd3};
      step(e, 1'($urandom), alu, $urandom, t);
      if (k inside {K_BEQ, K_J, K_JR}) m_cnt++;
      if (++ncyc == limit || k inside {K_BEQ, K_J, K_JR}) return;
      if (k inside {K_LW, K_SW}) begin
         for (int i = 0; ; i++) begin
            rdy = i >= nwait;
            e = base(3'd3);
            e.mreq = 1'b1;
            e.mw = k == K_SW;
            e.to = !rdy && i == TO - 1;
            step(e, rdy, $urandom, $urandom, t);
            if (rdy && k == K_SW) m_cnt++;
            if (++ncyc == limit || e.to || (rdy && k == K_SW)) return;
            if (rdy) break;
         end
      end
      e = base(3'd4);
      e.we = 1'b1;
      step(e, 1'($urandom), $urandom, $urandom, t);
      m_cnt++;
      ncyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1 chk("rst_async", 32'(observe()), 32'h0);
      m_ir = '0;
      m_cnt = '0;
      repeat (2) @(posedge clk);
      #1 chk("rst_hold", 32'(observe()), 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      skip_edge = 1'b1;
   endtask

   // Single compare process: every modelled cycle is checked mid-cycle
   initial begin
      obs_t e;
      string t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_chk++;
            if (observe() !== e) begin
               n_fail++;
               $display("FAIL cycle %s @%0t: got %h required %h", t, $time, observe(), e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.Instr = '0;
      bus.ALU_out = '0;
      bus.mem_ready = 1'b0;
      do_reset();
      run_instr(32'h00221820, 0, 0, 0, n);
      chk("add_lat", n, 4);
      chk("add_cnt", 32'(m_cnt), 1);
      run_instr(32'h8C050004, $urandom, 3, 0, n);
      chk("lw_lat", n, 8);
      chk("lw_cnt", 32'(m_cnt), 2);
      run_instr(32'h10000001, 0, 0, 0, n);
      chk("beq_taken_lat", n, 3);
      run_instr(32'h10000001, 5, 0, 0, n);
      chk("beq_not_lat", n, 3);
      chk("beq_cnt", 32'(m_cnt), 4);
      run_instr(32'h0C000010, $urandom, 0, 0, n);
      chk("jal_lat", n, 4);
      chk("jal_cnt", 32'(m_cnt), 5);
      run_instr(32'hFC000000, $urandom, 0, 0, n);
      chk("illegal_lat", n, 2);
      chk("illegal_cnt", 32'(m_cnt), 5);
      run_instr(32'hAC000000, $urandom, 1000, 0, n);
      chk("sw_timeout_lat", n, 19);
      chk("sw_timeout_cnt", 32'(m_cnt), 5);
      run_instr(32'h8C050004, $urandom, TO - 1, 0, n);
      chk("lw_late_ready_lat", n, 20);
      run_instr(32'hAC000000, $urandom, TO - 1, 0, n);
      chk("sw_late_ready_lat", n, 19);
      chk("late_ready_cnt", 32'(m_cnt), 7);
      run_instr(32'h0, $urandom, 0, 0, n);
      chk("nop_lat", n, 2);
      chk("nop_cnt", 32'(m_cnt), 8);
      run_instr(32'h8C050004, $urandom, 3, 4, n);
      do_reset();
      chk("abort_cnt", 32'(m_cnt), 0);
      run_instr(32'h00221820, $urandom, 0, 0, n);
      chk("post_abort_lat", n, 4);
      while (m_cnt != '1) run_instr(32'h0, $urandom, 0, 0, n);
      chk("wrap_pre", 32'(m_cnt), 32'hFF);
      run_instr(32'h0, $urandom, 0, 0, n);
      chk("wrap", 32'(m_cnt), 0);
      repeat (300) begin
         int lim;
         lim = $urandom_range(0, 19) == 0 ? $urandom_range(1, 5) : 0;
         run_instr(rand_instr(), $urandom_range(0, 1) ? '0 : $urandom,
                   $urandom_range(0, 9) == 0 ? 40 : $urandom_range(0, 5), lim, n);
         if (lim != 0) do_reset();
      end
      @(posedge clk);
      repeat (2) @(negedge clk);
      #1 chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
